sm_instr_encoder: RTL

- Encoder counterpart to the CPU's instruction decode path.
- Accepts symbolic instructions (operation, register fields, immediate, branch target) over a valid/ready stream. Encodes each into a 32-bit MIPS machine word and writes it sequentially into the instruction-memory write port.
- Used by the on-chip program loader and by self-checking benches that build test programs in hardware.

---
 rtl/sm_cpu_config.sv | 43 ++++
 rtl/sm_instr_encoder_if.sv | 35 +++
 rtl/sm_instr_encoder_pack.sv | 52 +++++
 rtl/sm_instr_encoder.sv | 88 ++++++++
 4 files changed

// File: rtl/sm_cpu_config.sv
// Shared CPU configuration: assembler op codes, MIPS opcode/funct values,
// encoder state encoding, error codes and word-building helpers.
package sm_cpu_config;

    typedef enum logic [3:0] {
        ASM_ADDIU, ASM_LUI, ASM_LW, ASM_SW, ASM_BEQ, ASM_BNE,
        ASM_ADDU, ASM_OR, ASM_SRL, ASM_SLTU, ASM_SUBU
    } Asm_Op;

    // Primary opcodes (bits 31:26)
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;

    // R-type funct values (bits 5:0)
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    typedef enum logic [1:0] {ENC_IDLE, ENC_RUN, ENC_FULL, ENC_ERROR} Enc_State;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL_OP   = 2'd1;
    localparam logic [1:0] ERR_BRANCH_RANGE = 2'd2;

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, shamt, fn};
    endfunction

endpackage

// File: rtl/sm_instr_encoder_if.sv
// Command stream, instruction-memory write port and status of the encoder.
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready never depends on cmd_valid, and the
// producer keeps the command fields stable while cmd_valid is high and
// cmd_ready is low.
interface sm_instr_encoder_if #(parameter int ADDR_WIDTH = 6);
    logic                  start;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3:0]            cmd_op;
    logic [4:0]            cmd_rs;
    logic [4:0]            cmd_rt;
    logic [4:0]            cmd_rd;
    logic [4:0]            cmd_shamt;
    logic [15:0]           cmd_imm;
    logic [ADDR_WIDTH-1:0] cmd_target;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wd;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  err;
    logic [1:0]            err_code;
    logic [1:0]            dbg_state;

    modport master (
        output start, cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm, cmd_target,
        input  cmd_ready, imem_we, imem_addr, imem_wd, count, full, err, err_code, dbg_state
    );

    modport slave (
        input  start, cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm, cmd_target,
        output cmd_ready, imem_we, imem_addr, imem_wd, count, full, err, err_code, dbg_state
    );
endinterface

// File: rtl/sm_instr_encoder_pack.sv
// Combinational packer: symbolic fields plus current write pointer become
// a 32-bit MIPS word and an error code (0 ok, 1 illegal op, 2 branch range).
module sm_instr_pack
    import sm_cpu_config::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic [3:0]            op,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [15:0]           imm,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic [ADDR_WIDTH-1:0] ptr,
    output logic [31:0]           word,
    output logic [1:0]            err_code
);
    localparam int OW = ADDR_WIDTH + 1;

    // Branch offset is relative to the word after the branch itself.
    logic [OW-1:0] off_raw;
    logic [31:0]   off_ext;
    logic          br_fits;

    assign off_raw = {1'b0, target} - {1'b0, ptr} - OW'(1);
    assign off_ext = {{(32-OW){off_raw[OW-1]}}, off_raw};
    assign br_fits = (off_ext[31:15] == {17{off_ext[15]}});

    // Select the instruction format and fixed fields for the requested op.
    always_comb begin
        word     = 32'd0;
        err_code = ERR_NONE;
        case (op)
            ASM_ADDIU: word = i_type(OPC_ADDIU, rs, rt, imm);
            ASM_LUI:   word = i_type(OPC_LUI, 5'd0, rt, imm);
            ASM_LW:    word = i_type(OPC_LW, rs, rt, imm);
            ASM_SW:    word = i_type(OPC_SW, rs, rt, imm);
            ASM_BEQ:   word = i_type(OPC_BEQ, rs, rt, off_ext[15:0]);
            ASM_BNE:   word = i_type(OPC_BNE, rs, rt, off_ext[15:0]);
            ASM_ADDU:  word = r_type(rs, rt, rd, 5'd0, FN_ADDU);
            ASM_OR:    word = r_type(rs, rt, rd, 5'd0, FN_OR);
            ASM_SRL:   word = r_type(5'd0, rt, rd, shamt, FN_SRL);
            ASM_SLTU:  word = r_type(rs, rt, rd, 5'd0, FN_SLTU);
            ASM_SUBU:  word = r_type(rs, rt, rd, 5'd0, FN_SUBU);
            default:   err_code = ERR_ILLEGAL_OP;
        endcase
        if ((op == ASM_BEQ || op == ASM_BNE) && !br_fits) begin
            err_code = ERR_BRANCH_RANGE;
        end
    end
endmodule

// File: rtl/sm_instr_encoder.sv
// Instruction encoder top: run/full/error FSM, write pointer, word count
// and the registered instruction-memory write port.
module sm_instr_encoder
    import sm_cpu_config::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic           clk,
    input  logic           rst,
    sm_instr_encoder_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = ENC_IDLE;
    localparam logic [1:0] ST_RUN   = ENC_RUN;
    localparam logic [1:0] ST_FULL  = ENC_FULL;
    localparam logic [1:0] ST_ERROR = ENC_ERROR;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  ready;
    logic                  xfer;
    logic [31:0]           word;
    logic [1:0]            code;

    // start wins over a command presented in the same cycle
    assign ready         = (state == ST_RUN) && !bus.start;
    assign xfer          = bus.cmd_valid && ready;
    assign bus.cmd_ready = ready;
    assign bus.dbg_state = state;

    sm_instr_pack #(.ADDR_WIDTH(ADDR_WIDTH)) u_pack (
        .op      (bus.cmd_op),
        .rs      (bus.cmd_rs),
        .rt      (bus.cmd_rt),
        .rd      (bus.cmd_rd),
        .shamt   (bus.cmd_shamt),
        .imm     (bus.cmd_imm),
        .target  (bus.cmd_target),
        .ptr     (ptr),
        .word    (word),
        .err_code(code)
    );

    // FSM, pointer/count bookkeeping and one-cycle-delayed memory write
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= FIRST_ADDR;
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= '0;
            bus.imem_wd   <= 32'd0;
            bus.count     <= '0;
            bus.full      <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_code  <= ERR_NONE;
        end else begin
            bus.imem_we <= 1'b0;
            if (bus.start) begin
                state        <= ST_RUN;
                ptr          <= FIRST_ADDR;
                bus.count    <= '0;
                bus.full     <= 1'b0;
                bus.err      <= 1'b0;
                bus.err_code <= ERR_NONE;
            end else if (xfer) begin
                if (code != ERR_NONE) begin
                    state        <= ST_ERROR;
                    bus.err      <= 1'b1;
                    bus.err_code <= code;
                end else begin
                    bus.imem_we   <= 1'b1;
                    bus.imem_addr <= ptr;
                    bus.imem_wd   <= word;
                    bus.count     <= bus.count + (ADDR_WIDTH+1)'(1);
                    if (ptr == LAST_ADDR) begin
                        state    <= ST_FULL;
                        bus.full <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end
endmodule
